phase_select: RTL and testbench

PHASE_SELECT -- requirements
Module: phase_select

---
 rtl/phase_select_pkg.sv | 17 +
 rtl/phase_select_argmax_sel.sv | 28 ++
 rtl/phase_select.sv | 171 +++++++++++++++++
 tb/tb_phase_select.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/phase_select_pkg.sv
// Shared types and default sizing for the symbol-phase selector.
// The FSM state encoding lives here so the top and any observers agree on it.
package phase_select_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        ACCUM  = 2'd2,
        DECIDE = 2'd3
    } state_t;

    localparam int DEF_NB       = 8;
    localparam int DEF_OS       = 4;
    localparam int DEF_LOG2_WIN = 10;
    localparam int DEF_NB_ACC   = 24;

endpackage

// File: rtl/phase_select_argmax_sel.sv
// Combinational arg-max over OS per-phase energy accumulators.
// A strict greater-than compare keeps the lowest index on ties.
module argmax_sel
    import phase_select_pkg::*;
#(
    parameter int OS     = DEF_OS,
    parameter int NB_ACC = DEF_NB_ACC
) (
    input  logic [OS-1:0][NB_ACC-1:0] acc,
    output logic [$clog2(OS)-1:0]     idx
);

    localparam int IW = $clog2(OS);

    logic [NB_ACC-1:0] best;

    always_comb begin
        best = acc[0];
        idx  = '0;
        for (int i = 1; i < OS; i++) begin
            if (acc[i] > best) begin
                best = acc[i];
                idx  = IW'(i);
            end
        end
    end

endmodule

// File: rtl/phase_select.sv
// Picks the sampling phase with the largest |sample| energy over a window of symbols.
// Optional macro PHASE_SELECT_HYST_EN adds 1/8 hysteresis to offset changes while locked.
module phase_select
    import phase_select_pkg::*;
#(
    parameter int NB       = DEF_NB,
    parameter int OS       = DEF_OS,
    parameter int LOG2_WIN = DEF_LOG2_WIN,
    parameter int NB_ACC   = DEF_NB_ACC
) (
    input  logic                   clock,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic                   i_valid,
    input  logic signed [NB-1:0]   i_sample,
    output logic [$clog2(OS)-1:0]  o_offset,
    output logic                   o_lock
);

    localparam int IW = $clog2(OS);
    localparam logic [LOG2_WIN-1:0] SYM_LAST = '1;

    state_t                state_reg, state_next;
    logic [IW-1:0]         phase_reg, phase_next;
    logic [LOG2_WIN-1:0]   sym_cnt_reg, sym_cnt_next;
    logic [IW-1:0]         offset_reg, offset_next;
    logic                  lock_reg, lock_next;

    logic [NB_ACC-1:0]         acc_reg [OS];
    logic [OS-1:0][NB_ACC-1:0] acc_bus;
    logic [NB-2:0]             mag;
    logic [IW-1:0]             cur_phase;
    logic [IW-1:0]             add_idx;
    logic                      acc_add;
    logic                      acc_clear;
    logic [IW-1:0]             best_idx;

    // Saturating magnitude: the most negative code folds onto the largest positive one.
    always_comb begin
        if (!i_sample[NB-1])
            mag = i_sample[NB-2:0];
        else if (i_sample[NB-2:0] == '0)
            mag = '1;
        else
            mag = ~i_sample[NB-2:0] + 1'b1;
    end

    assign cur_phase = i_valid ? '0 : phase_reg + 1'b1;

    always_comb begin
        for (int i = 0; i < OS; i++)
            acc_bus[i] = acc_reg[i];
    end

    argmax_sel #(
        .OS     (OS),
        .NB_ACC (NB_ACC)
    ) u_argmax (
        .acc (acc_bus),
        .idx (best_idx)
    );

`ifdef PHASE_SELECT_HYST_EN
    logic [NB_ACC-1:0] cur_acc;
    logic [NB_ACC:0]   hyst_thr;
    logic              hyst_pass;

    assign cur_acc   = acc_reg[offset_reg];
    assign hyst_thr  = {1'b0, cur_acc} + {1'b0, (cur_acc >> 3)};
    assign hyst_pass = {1'b0, acc_reg[best_idx]} > hyst_thr;
`endif

    always_comb begin
        state_next   = state_reg;
        phase_next   = phase_reg;
        sym_cnt_next = sym_cnt_reg;
        offset_next  = offset_reg;
        lock_next    = lock_reg;
        acc_add      = 1'b0;
        acc_clear    = 1'b0;
        add_idx      = '0;

        case (state_reg)
            IDLE: begin
                if (i_enable)
                    state_next = SYNC;
            end
            SYNC: begin
                if (i_valid) begin
                    acc_add      = 1'b1;
                    add_idx      = '0;
                    phase_next   = '0;
                    sym_cnt_next = '0;
                    state_next   = ACCUM;
                end
            end
            ACCUM: begin
                phase_next = cur_phase;
                // The strobe that closes the window belongs to no window.
                if (i_valid && sym_cnt_reg == SYM_LAST) begin
                    state_next = DECIDE;
                end else begin
                    acc_add = 1'b1;
                    add_idx = cur_phase;
                    if (i_valid)
                        sym_cnt_next = sym_cnt_reg + 1'b1;
                end
            end
            DECIDE: begin
                acc_clear  = 1'b1;
                lock_next  = 1'b1;
                state_next = SYNC;
`ifdef PHASE_SELECT_HYST_EN
                if (!lock_reg || hyst_pass)
                    offset_next = best_idx;
`else
                offset_next = best_idx;
`endif
            end
            default: state_next = IDLE;
        endcase

        if (!i_enable) begin
            state_next   = IDLE;
            phase_next   = '0;
            sym_cnt_next = '0;
            lock_next    = 1'b0;
            acc_clear    = 1'b1;
            acc_add      = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_reg   <= IDLE;
            phase_reg   <= '0;
            sym_cnt_reg <= '0;
            offset_reg  <= '0;
            lock_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            phase_reg   <= phase_next;
            sym_cnt_reg <= sym_cnt_next;
            offset_reg  <= offset_next;
            lock_reg    <= lock_next;
        end
    end

    generate
        for (genvar gi = 0; gi < OS; gi++) begin : g_acc
            logic [NB_ACC:0] sum;
            logic            hit;

            assign sum = {1'b0, acc_reg[gi]} + {{(NB_ACC + 2 - NB){1'b0}}, mag};
            assign hit = acc_add && (add_idx == IW'(gi));

            always_ff @(posedge clock or negedge i_reset) begin
                if (!i_reset)
                    acc_reg[gi] <= '0;
                else if (acc_clear)
                    acc_reg[gi] <= '0;
                else if (hit)
                    acc_reg[gi] <= sum[NB_ACC] ? {NB_ACC{1'b1}} : sum[NB_ACC-1:0];
            end
        end
    endgenerate

    assign o_offset = offset_reg;
    assign o_lock   = lock_reg;

endmodule

// File: tb/tb_phase_select.sv
// Directed bench for phase_select: window vectors from a table plus hand-written
// enable-drop, async-reset and long-window saturation sequences.
module tb_phase_select;
    import phase_select_pkg::*;

    logic              clock = 1'b0;
    logic              i_reset;
    logic              i_enable;
    logic              i_valid;
    logic signed [7:0] i_sample;
    logic [1:0]        o_offset;
    logic              o_lock;

    logic              big_enable;
    logic              big_valid;
    logic signed [7:0] big_sample;
    logic [1:0]        big_offset;
    logic              big_lock;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    phase_select #(.NB(8), .OS(4), .LOG2_WIN(2), .NB_ACC(12)) dut (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_valid  (i_valid),
        .i_sample (i_sample),
        .o_offset (o_offset),
        .o_lock   (o_lock)
    );

    phase_select #(.NB(8), .OS(4), .LOG2_WIN(10), .NB_ACC(16)) big (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_enable (big_enable),
        .i_valid  (big_valid),
        .i_sample (big_sample),
        .o_offset (big_offset),
        .o_lock   (big_lock)
    );

    typedef struct {
        logic [3:0][7:0]  mag;
        logic [3:0][15:0] acc;
        int               off;
        int               off_h;
    } vec_t;

    function automatic vec_t mk(input int m0, input int m1, input int m2, input int m3,
                                input int a0, input int a1, input int a2, input int a3,
                                input int off, input int off_h);
        vec_t v;
        v.mag[0] = 8'(m0); v.mag[1] = 8'(m1); v.mag[2] = 8'(m2); v.mag[3] = 8'(m3);
        v.acc[0] = 16'(a0); v.acc[1] = 16'(a1); v.acc[2] = 16'(a2); v.acc[3] = 16'(a3);
        v.off   = off;
        v.off_h = off_h;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_cycle(input logic v, input logic signed [7:0] s);
        i_valid  = v;
        i_sample = s;
        @(posedge clock);
        #1;
    endtask

    task automatic drive_symbol(input logic [3:0][7:0] m, input bit neg);
        logic signed [7:0] s;
        for (int p = 0; p < 4; p++) begin
            s = m[p];
            if (neg)
                s = -s;
            drive_cycle(p == 0, s);
        end
    endtask

    // Four accumulated symbols, then the closing strobe; checks sums in DECIDE and 2-clock latency.
    task automatic run_window(input vec_t v, input int exp_off, input int prev_off, input string tag);
        for (int k = 0; k < 4; k++)
            drive_symbol(v.mag, k[0]);
        drive_cycle(1'b1, v.mag[0]);
        check({tag, "_state_decide"}, int'(dut.state_reg), int'(DECIDE));
        for (int p = 0; p < 4; p++)
            check($sformatf("%s_acc%0d", tag, p), int'(dut.acc_reg[p]), int'(v.acc[p]));
        check({tag, "_offset_before"}, int'(o_offset), prev_off);
        drive_cycle(1'b0, v.mag[1]);
        check({tag, "_offset"}, int'(o_offset), exp_off);
        check({tag, "_lock"}, int'(o_lock), 1);
        drive_cycle(1'b0, v.mag[2]);
        drive_cycle(1'b0, v.mag[3]);
        $display("window %s: offset=%0d lock=%0d", tag, o_offset, o_lock);
    endtask

    vec_t vecs [7];
    vec_t vfix;
    vec_t vrst;
    logic [3:0][7:0] part;
    int prev;
    int exp;

    initial begin
        vecs[0] = mk( 20,  20, 100,  20,   80,  80, 400,  80, 2, 2);
        vecs[1] = mk( 50,  50,  50,  50,  200, 200, 200, 200, 0, 2);
        vecs[2] = mk( 10, 120,  30, 127,   40, 480, 120, 508, 3, 3);
        vecs[3] = mk(-128,-128,-128,-128, 508, 508, 508, 508, 0, 3);
        vecs[4] = mk(  0,   0,   0,   5,    0,   0,   0,  20, 3, 3);
        vecs[5] = mk(  0, 100,   0,   0,    0, 400,   0,   0, 1, 1);
        vecs[6] = mk(  0, 100,   0, 105,    0, 400,   0, 420, 3, 1);
        vfix    = mk(  0, 100,   0, 105,    0, 400,   0, 420, 3, 3);
        vrst    = mk(  0,   0,   0,  70,    0,   0,   0, 280, 3, 3);

        i_reset    = 1'b0;
        i_enable   = 1'b0;
        i_valid    = 1'b0;
        i_sample   = '0;
        big_enable = 1'b0;
        big_valid  = 1'b0;
        big_sample = '0;

        repeat (3) @(posedge clock);
        #1;
        check("reset_offset", int'(o_offset), 0);
        check("reset_lock", int'(o_lock), 0);
        check("reset_state", int'(dut.state_reg), int'(IDLE));

        i_reset = 1'b1;
        drive_cycle(1'b1, 8'sd30);
        check("idle_holds", int'(dut.state_reg), int'(IDLE));
        i_enable = 1'b1;
        drive_cycle(1'b0, 8'sd0);
        check("idle_to_sync", int'(dut.state_reg), int'(SYNC));
        drive_cycle(1'b0, 8'sd0);

        prev = 0;
        for (int i = 0; i < 7; i++) begin
`ifdef PHASE_SELECT_HYST_EN
            exp = vecs[i].off_h;
`else
            exp = vecs[i].off;
`endif
            run_window(vecs[i], exp, prev, $sformatf("vec%0d", i));
            prev = exp;
        end

        // Enable dropped mid-window: lock clears, offset holds, sums cleared.
        part[0] = 8'd40; part[1] = 8'd40; part[2] = 8'd40; part[3] = 8'd40;
        drive_symbol(part, 1'b0);
        drive_symbol(part, 1'b1);
        i_enable = 1'b0;
        drive_cycle(1'b0, 8'sd0);
        check("dis_state", int'(dut.state_reg), int'(IDLE));
        check("dis_lock", int'(o_lock), 0);
        check("dis_offset_held", int'(o_offset), prev);
        check("dis_acc_clear", int'(dut.acc_reg[0]), 0);
        drive_cycle(1'b0, 8'sd0);
        check("dis_offset_held2", int'(o_offset), prev);
        $display("disable: offset=%0d lock=%0d", o_offset, o_lock);

        // Re-enable: SYNC must ignore samples until the first strobe.
        i_enable = 1'b1;
        drive_cycle(1'b0, 8'sd100);
        repeat (3) drive_cycle(1'b0, 8'sd100);
        check("reen_sync_wait", int'(dut.state_reg), int'(SYNC));
        run_window(vfix, 3, prev, "reenable");
        prev = 3;

        // Async reset in the middle of a window.
        part[0] = 8'd90; part[1] = 8'd0; part[2] = 8'd0; part[3] = 8'd0;
        drive_symbol(part, 1'b0);
        drive_symbol(part, 1'b0);
        #2;
        i_reset = 1'b0;
        #1;
        check("async_rst_offset", int'(o_offset), 0);
        check("async_rst_lock", int'(o_lock), 0);
        check("async_rst_acc0", int'(dut.acc_reg[0]), 0);
        $display("async reset: offset=%0d lock=%0d", o_offset, o_lock);
        drive_cycle(1'b0, 8'sd0);
        i_reset = 1'b1;
        drive_cycle(1'b0, 8'sd0);
        drive_cycle(1'b0, 8'sd0);
        run_window(vrst, 3, 0, "post_reset");

        // Long window of full-scale negative samples on the wide instance.
        big_enable = 1'b1;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        for (int k = 0; k < 1025; k++) begin
            for (int p = 0; p < 4; p++) begin
                big_valid  = (p == 0);
                big_sample = -8'sd128;
                @(posedge clock);
                #1;
                if (k == 1024 && p == 0) begin
                    check("big_state_decide", int'(big.state_reg), int'(DECIDE));
                    for (int q = 0; q < 4; q++)
                        check($sformatf("big_acc%0d_sat", q), int'(big.acc_reg[q]), 65535);
                end
                if (k == 1024 && p == 1) begin
                    check("big_offset", int'(big_offset), 0);
                    check("big_lock", int'(big_lock), 1);
                end
            end
        end
        big_valid = 1'b0;
        $display("big window: offset=%0d lock=%0d", big_offset, big_lock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
